// File: rtl/stim_sequencer_pkg.sv
// Shared types and helpers for the stimulation trial sequencer.
// Holds the FSM state encoding and the zero-as-one config normalisation.
package stim_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_REST  = 2'd3
  } state_e;

  // Divider and period registers treat a programmed 0 as 1.
  function automatic logic [31:0] zero_as_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/stim_sequencer_tick_divider.sv
// Enable-gated programmable strobe: ticks on the first enabled clock, then every div_i clocks.
// clr_i restarts the count so the next enabled clock ticks again.
module stim_sequencer_tick_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_i - W'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Paces a table-based sample source into ON/REST trials and emits frame markers
// aligned with the source's registered data_valid (one stage after src_enable).
module stim_sequencer
  import stim_sequencer_pkg::*;
#(
  parameter int M       = 16,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16,
  parameter int TRIAL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_periods,
  input  logic [CNT_W-1:0]   cfg_rest,
  input  logic [TRIAL_W-1:0] cfg_trials,
  output logic               src_enable,
  output logic               sop,
  output logic               eop,
  output logic               discard,
  output logic [TRIAL_W-1:0] trial_idx,
  output logic               busy,
  output logic               done,
  output state_e             dbg_state
);

  localparam int LOG2M  = $clog2(M);
  localparam int PH_W   = (LOG2M > 0) ? LOG2M : 1;
  localparam int SAMP_W = CNT_W + LOG2M;
  localparam int TW1    = TRIAL_W + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(M - 1);

  state_e               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 src_en_q, src_en_d;
  logic                 sop_tag_q, sop_tag_d, eop_tag_q, eop_tag_d, disc_tag_q, disc_tag_d;
  logic                 sop_q, eop_q, disc_q;
  logic                 done_q, done_d;
  logic [TRIAL_W-1:0]   trial_q, trial_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [CNT_W-1:0]     rest_cnt_q, rest_cnt_d;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     periods_q, rest_q;
  logic [TRIAL_W-1:0]   trials_q;
  logic                 start_acc, tick, div_en, div_clr;
  logic [SAMP_W-1:0]    total_m1;

  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign total_m1  = SAMP_W'(periods_q) * SAMP_W'(M) - SAMP_W'(1);
  assign phase_d   = !src_en_q ? phase_q : ((phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1));

  // The divider free-runs from RUN into REST so rest ticks keep the sample pacing.
  assign div_en  = (state_q == ST_RUN) || (state_q == ST_REST);
  assign div_clr = (state_d == ST_RUN) && (state_q != ST_RUN);

  stim_sequencer_tick_divider #(.W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (div_en),
    .clr_i   (div_clr),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state_q;
    src_en_d   = 1'b0;
    sop_tag_d  = 1'b0;
    eop_tag_d  = 1'b0;
    disc_tag_d = 1'b0;
    done_d     = 1'b0;
    trial_d    = trial_q;
    samp_d     = samp_q;
    rest_cnt_d = rest_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          trial_d    = '0;
          samp_d     = '0;
          rest_cnt_d = '0;
          if (cfg_trials == '0)    state_d = ST_REST;
          else if (phase_d != '0)  state_d = ST_ALIGN;
          else                     state_d = ST_RUN;
        end
      end
      ST_ALIGN: begin
        // phase_d is the index the enable issued now will consume.
        src_en_d   = 1'b1;
        disc_tag_d = 1'b1;
        if (phase_d == PH_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          src_en_d  = 1'b1;
          samp_d    = samp_q + SAMP_W'(1);
          sop_tag_d = (samp_q == '0);
          eop_tag_d = (samp_q == total_m1);
          if (samp_q == total_m1) begin
            state_d    = ST_REST;
            rest_cnt_d = '0;
          end
        end
      end
      ST_REST: begin
        if (trials_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if ((rest_q == '0) || (tick && (rest_cnt_q == rest_q - CNT_W'(1)))) begin
          if ((TW1'(trial_q) + TW1'(1)) < TW1'(trials_q)) begin
            state_d = ST_RUN;
            trial_d = trial_q + TRIAL_W'(1);
            samp_d  = '0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          rest_cnt_d = rest_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d    = ST_IDLE;
      src_en_d   = 1'b0;
      sop_tag_d  = 1'b0;
      eop_tag_d  = 1'b0;
      disc_tag_d = 1'b0;
      done_d     = 1'b0;
      trial_d    = trial_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      src_en_q   <= 1'b0;
      sop_tag_q  <= 1'b0;
      eop_tag_q  <= 1'b0;
      disc_tag_q <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      disc_q     <= 1'b0;
      done_q     <= 1'b0;
      trial_q    <= '0;
      samp_q     <= '0;
      rest_cnt_q <= '0;
      div_q      <= DIV_W'(1);
      periods_q  <= CNT_W'(1);
      rest_q     <= '0;
      trials_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      src_en_q   <= src_en_d;
      sop_tag_q  <= sop_tag_d;
      eop_tag_q  <= eop_tag_d;
      disc_tag_q <= disc_tag_d;
      sop_q      <= sop_tag_q;
      eop_q      <= eop_tag_q;
      disc_q     <= disc_tag_q;
      done_q     <= done_d;
      trial_q    <= trial_d;
      samp_q     <= samp_d;
      rest_cnt_q <= rest_cnt_d;
      if (start_acc) begin
        div_q     <= DIV_W'(zero_as_one(32'(cfg_div)));
        periods_q <= CNT_W'(zero_as_one(32'(cfg_periods)));
        rest_q    <= cfg_rest;
        trials_q  <= cfg_trials;
      end
    end
  end

  assign src_enable = src_en_q;
  assign sop        = sop_q;
  assign eop        = eop_q;
  assign discard    = disc_q;
  assign trial_idx  = trial_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: a cycle monitor models the source phase and
// collects enable gaps, which are scored against hand-computed expected queues.
module tb_stim_sequencer;
  import stim_sequencer_pkg::*;

  localparam int M = 16, DIV_W = 16, CNT_W = 16, TRIAL_W = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0, abort = 1'b0;
  logic [DIV_W-1:0]   cfg_div = '0;
  logic [CNT_W-1:0]   cfg_periods = '0, cfg_rest = '0;
  logic [TRIAL_W-1:0] cfg_trials = '0;
  logic               src_enable, sop, eop, discard, busy, done;
  logic [TRIAL_W-1:0] trial_idx;
  state_e             dbg_state;

  stim_sequencer #(.M(M), .DIV_W(DIV_W), .CNT_W(CNT_W), .TRIAL_W(TRIAL_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_div(cfg_div), .cfg_periods(cfg_periods), .cfg_rest(cfg_rest), .cfg_trials(cfg_trials),
    .src_enable(src_enable), .sop(sop), .eop(eop), .discard(discard),
    .trial_idx(trial_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, ph = 0, prev_ph = 0;
  logic prev_en = 1'b0;
  int en_cnt, disc_cnt, sop_cnt, eop_cnt, done_cnt, busy_cnt;
  int sop_cyc, eop_cyc, done_cyc, first_en_cyc, last_en_cyc, start_cyc;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; disc_cnt = 0; sop_cnt = 0; eop_cnt = 0; done_cnt = 0; busy_cnt = 0;
    sop_cyc = -1; eop_cyc = -1; done_cyc = -1; first_en_cyc = -1; last_en_cyc = -1;
    obs_q.delete();
    exp_q.delete();
  endtask

  // One clock: sample outputs #1 after the edge and update the source model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sop || eop || discard) check_eq("marker_valid", 32'(prev_en), 32'd1);
    if (sop) begin
      check_eq("sop_phase", 32'(prev_ph), 32'd0);
      check_eq("sop_trial", 32'(trial_idx), 32'(sop_cnt));
      sop_cnt++;
      sop_cyc = cyc;
    end
    if (eop) begin
      check_eq("eop_phase", 32'(prev_ph), 32'(M - 1));
      eop_cnt++;
      eop_cyc = cyc;
    end
    if (discard) disc_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    prev_en = src_enable;
    prev_ph = ph;
    if (src_enable) begin
      en_cnt++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (last_en_cyc >= 0) obs_q.push_back(32'(cyc - last_en_cyc));
      last_en_cyc = cyc;
      ph = (ph + 1) % M;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic set_cfg(input int d, input int p, input int r, input int t);
    cfg_div = DIV_W'(d); cfg_periods = CNT_W'(p); cfg_rest = CNT_W'(r); cfg_trials = TRIAL_W'(t);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    check_eq("done_within_budget", 32'(done_cnt != 0), 32'd1);
    repeat (3) step();
  endtask

  task automatic push_gaps(input int count, input int gap);
    for (int i = 0; i < count; i++) exp_q.push_back(32'(gap));
  endtask

  task automatic score_gaps(input string tag);
    check_eq({tag, "_gap_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_gap"}, obs_q[i], exp_q[i]);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_src_enable", 32'(src_enable), 32'd0);
    check_eq("rst_markers", 32'({sop, eop, discard}), 32'd0);
    check_eq("rst_busy_done", 32'({busy, done}), 32'd0);
    check_eq("rst_trial_idx", 32'(trial_idx), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    repeat (2) step();

    // Two trials of 2 periods at 4 clocks/sample, 3-tick rest.
    clear_stats();
    set_cfg(4, 2, 3, 2);
    pulse_start();
    wait_done(1000);
    check_eq("t1_enables", 32'(en_cnt), 32'd64);
    check_eq("t1_sop", 32'(sop_cnt), 32'd2);
    check_eq("t1_eop", 32'(eop_cnt), 32'd2);
    check_eq("t1_done", 32'(done_cnt), 32'd1);
    check_eq("t1_discard", 32'(disc_cnt), 32'd0);
    check_eq("t1_trial_idx", 32'(trial_idx), 32'd1);
    check_eq("t1_first_latency", 32'(first_en_cyc - start_cyc), 32'd1);
    check_eq("t1_done_after_last", 32'(done_cyc - last_en_cyc), 32'd12);
    push_gaps(31, 4); push_gaps(1, 13); push_gaps(31, 4);
    score_gaps("t1");

    // Full-rate single trial, no rest.
    clear_stats();
    set_cfg(1, 1, 0, 1);
    pulse_start();
    wait_done(200);
    check_eq("t2_enables", 32'(en_cnt), 32'd16);
    check_eq("t2_sop_eop_span", 32'(eop_cyc - sop_cyc), 32'd15);
    check_eq("t2_done_after_last", 32'(done_cyc - last_en_cyc), 32'd1);
    check_eq("t2_first_latency", 32'(first_en_cyc - start_cyc), 32'd1);
    push_gaps(15, 1);
    score_gaps("t2");

    // Zero trials: one busy cycle, done, no samples.
    clear_stats();
    set_cfg(4, 1, 5, 0);
    pulse_start();
    repeat (4) step();
    check_eq("t0_busy_cycles", 32'(busy_cnt), 32'd1);
    check_eq("t0_done", 32'(done_cnt), 32'd1);
    check_eq("t0_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    check_eq("t0_enables", 32'(en_cnt), 32'd0);

    // Abort and start together while idle.
    clear_stats();
    set_cfg(1, 1, 0, 1);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    repeat (10) step();
    check_eq("as_busy", 32'(busy_cnt), 32'd0);
    check_eq("as_enables", 32'(en_cnt), 32'd0);
    check_eq("as_done", 32'(done_cnt), 32'd0);

    // Restart attempt and divider change mid-run are ignored.
    clear_stats();
    set_cfg(3, 1, 0, 1);
    pulse_start();
    for (int n = 0; n < 100 && en_cnt < 4; n++) step();
    start = 1'b1; cfg_div = DIV_W'(7);
    step();
    start = 1'b0;
    wait_done(300);
    check_eq("mr_enables", 32'(en_cnt), 32'd16);
    check_eq("mr_sop", 32'(sop_cnt), 32'd1);
    check_eq("mr_done", 32'(done_cnt), 32'd1);
    push_gaps(15, 3);
    score_gaps("mr");

    // Abort after 5 enables, then restart re-aligns through ALIGN.
    clear_stats();
    set_cfg(2, 1, 0, 1);
    pulse_start();
    for (int n = 0; n < 100 && en_cnt < 5; n++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (6) step();
    check_eq("ab_enables", 32'(en_cnt), 32'd5);
    check_eq("ab_done", 32'(done_cnt), 32'd0);
    check_eq("ab_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("ab_trial_idx", 32'(trial_idx), 32'd0);
    clear_stats();
    cfg_div = DIV_W'(1);
    pulse_start();
    wait_done(200);
    check_eq("ra_discard", 32'(disc_cnt), 32'd11);
    check_eq("ra_enables", 32'(en_cnt), 32'd27);
    check_eq("ra_sop", 32'(sop_cnt), 32'd1);
    check_eq("ra_eop", 32'(eop_cnt), 32'd1);
    check_eq("ra_done", 32'(done_cnt), 32'd1);
    push_gaps(26, 1);
    score_gaps("ra");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
